serial_adder: RTL and testbench

- Bit-serial N-bit adder; one full-adder slice processes one bit per clock, LSB first.
- Carry is held in a flip-flop between bits.
- Sits directly around the existing 1-bit full_adder stage: feeds it operand bits and consumes its sum/carry outputs.
- Gives a multi-bit add with a start/valid handshake, at WIDTH cycles of latency instead of WIDTH adder slices.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
// Used by serial_adder (SERIAL_ADDER_OVF_EN selects the optional overflow output there).
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder slice; the only arithmetic in the serial adder.
module full_adder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);

    // Combinational sum and carry of three input bits.
    assign o_sum   = i_x ^ i_y ^ i_carry;
    assign o_carry = (i_x & i_y) | (i_carry & (i_x ^ i_y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder slice, LSB first, carry held in a flop.
// Optional build macro SERIAL_ADDER_OVF_EN adds the registered o_overflow output
// (signed overflow = carry into MSB XOR carry out of MSB).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             o_carry,
    output logic             o_overflow
`else
    output logic             o_carry
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    logic [WIDTH-1:0] r_x_sr;
    logic [WIDTH-1:0] r_y_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_cin_msb;
    logic             r_overflow;
`endif

    logic w_fa_sum;
    logic w_fa_carry;
    logic w_load;

    full_adder u_full_adder (
        .i_x     (r_x_sr[0]),
        .i_y     (r_y_sr[0]),
        .i_carry (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    // A start is accepted only when not shifting; DONE accepts too for back-to-back adds.
    assign w_load = i_start && (r_state == S_IDLE || r_state == S_DONE);

    // Control FSM, datapath shift registers and registered result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_x_sr      <= '0;
            r_y_sr      <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_cin_msb   <= 1'b0;
            r_overflow  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;

            // Result capture happens on the edge that leaves DONE, even if a new add starts.
            if (r_state == S_DONE) begin
                r_valid     <= 1'b1;
                r_sum       <= r_sum_sr;
                r_carry_out <= r_carry;
`ifdef SERIAL_ADDER_OVF_EN
                r_overflow  <= r_cin_msb ^ r_carry;
`endif
            end

            if (w_load) begin
                r_x_sr   <= i_x;
                r_y_sr   <= i_y;
                r_carry  <= i_carry;
                r_sum_sr <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_state  <= S_SHIFT;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        r_x_sr   <= r_x_sr >> 1;
                        r_y_sr   <= r_y_sr >> 1;
                        r_sum_sr <= (r_sum_sr >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
                        r_carry  <= w_fa_carry;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BIT) begin
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                            r_cin_msb <= r_carry;
`endif
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_sum   = r_sum;
    assign o_carry = r_carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    assign o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, scoreboard queues.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       c;
        logic       ovf;
    } exp8_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] x8 = '0;
    logic [7:0] y8 = '0;
    logic       c8 = 1'b0;
    logic       busy8, valid8, carry8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic       x1 = 1'b0;
    logic       y1 = 1'b0;
    logic       c1 = 1'b0;
    logic       busy1, valid1, carry1, sum1;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf1;
`endif

    exp8_t      q8[$];
    logic [1:0] q1[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start8),
        .i_x     (x8),
        .i_y     (y8),
        .i_carry (c8),
        .o_busy  (busy8),
        .o_valid (valid8),
        .o_sum   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .o_carry    (carry8),
        .o_overflow (ovf8)
`else
        .o_carry (carry8)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start1),
        .i_x     (x1),
        .i_y     (y1),
        .i_carry (c1),
        .o_busy  (busy1),
        .o_valid (valid1),
        .o_sum   (sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .o_carry    (carry1),
        .o_overflow (ovf1)
`else
        .o_carry (carry1)
`endif
    );

    function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        exp8_t      e;
        logic [8:0] full;
        logic [7:0] low;
        full  = {1'b0, x} + {1'b0, y} + {8'd0, c};
        low   = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, c};
        e.sum = full[7:0];
        e.c   = full[8];
        e.ovf = low[7] ^ full[8];
        return e;
    endfunction

    // Present operands, let the next rising edge accept them, push the expected result.
    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic c);
        @(negedge clk);
        start8 = 1'b1;
        x8 = x;
        y8 = y;
        c8 = c;
        q8.push_back(model8(x, y, c));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        x8 = 8'($urandom);
        y8 = 8'($urandom);
        c8 = 1'($urandom);
    endtask

    // Called just after the accepting edge; expects o_valid after exp_lat further edges.
    task automatic wait_result8(input string name, input int exp_lat);
        bit    seen;
        exp8_t e;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (valid8) begin
                seen = 1;
                n_cmp++;
                if (k !== exp_lat) begin
                    n_err++;
                    $display("FAIL %s latency: got %0d edges, expected %0d", name, k, exp_lat);
                end
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s: o_valid with empty scoreboard", name);
                end else begin
                    e = q8.pop_front();
                    n_cmp++;
                    if (sum8 !== e.sum || carry8 !== e.c) begin
                        n_err++;
                        $display("FAIL %s result: got sum=%02h c=%b, expected sum=%02h c=%b",
                                 name, sum8, carry8, e.sum, e.c);
                    end
`ifdef SERIAL_ADDER_OVF_EN
                    n_cmp++;
                    if (ovf8 !== e.ovf) begin
                        n_err++;
                        $display("FAIL %s overflow: got %b, expected %b", name, ovf8, e.ovf);
                    end
`endif
                    @(negedge clk);
                    n_cmp++;
                    if (valid8 !== 1'b0 || sum8 !== e.sum || carry8 !== e.c) begin
                        n_err++;
                        $display("FAIL %s hold: valid=%b sum=%02h c=%b, expected valid=0 sum=%02h c=%b",
                                 name, valid8, sum8, carry8, e.sum, e.c);
                    end
                end
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: no o_valid, expected after %0d edges", name, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy8, valid8, sum8, carry8} !== 11'd0) begin
            n_err++;
            $display("FAIL reset8: got busy=%b valid=%b sum=%02h c=%b, expected all 0",
                     busy8, valid8, sum8, carry8);
        end
        n_cmp++;
        if ({busy1, valid1, sum1, carry1} !== 4'd0) begin
            n_err++;
            $display("FAIL reset1: got %b%b%b%b, expected 0000", busy1, valid1, sum1, carry1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        issue8(8'h5A, 8'h3C, 1'b0);
        wait_result8("add_5A_3C", 9);
    endtask

    task automatic test_carry();
        issue8(8'hFF, 8'h01, 1'b0);
        wait_result8("add_FF_01", 9);
        issue8(8'hFF, 8'hFF, 1'b1);
        wait_result8("add_FF_FF_c1", 9);
        issue8(8'h00, 8'h00, 1'b1);
        wait_result8("add_00_00_c1", 9);
    endtask

    task automatic test_start_while_busy();
        int    busy_cnt;
        int    valid_cnt;
        exp8_t e;
        busy_cnt  = 0;
        valid_cnt = 0;
        issue8(8'h10, 8'h20, 1'b0);
        e = q8.pop_front();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (busy8) busy_cnt++;
            if (valid8) begin
                valid_cnt++;
                n_cmp++;
                if (sum8 !== e.sum || carry8 !== e.c) begin
                    n_err++;
                    $display("FAIL busy_ignore result: got sum=%02h c=%b, expected sum=%02h c=%b",
                             sum8, carry8, e.sum, e.c);
                end
            end
            start8 = (k == 2);
            if (k == 2) begin
                x8 = 8'hAA;
                y8 = 8'h55;
            end
        end
        n_cmp++;
        if (valid_cnt !== 1) begin
            n_err++;
            $display("FAIL busy_ignore valid count: got %0d, expected 1", valid_cnt);
        end
        n_cmp++;
        if (busy_cnt !== 8) begin
            n_err++;
            $display("FAIL busy_ignore busy cycles: got %0d, expected 8", busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int valid_cnt;
        valid_cnt = 0;
        issue8(8'h0F, 8'h01, 1'b0);
        void'(q8.pop_back());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy8, valid8, sum8, carry8} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_mid outputs: got busy=%b valid=%b sum=%02h c=%b, expected all 0",
                     busy8, valid8, sum8, carry8);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (valid8) valid_cnt++;
        end
        n_cmp++;
        if (valid_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_mid valid count: got %0d, expected 0", valid_cnt);
        end
        issue8(8'h0F, 8'h01, 1'b0);
        wait_result8("after_reset_0F_01", 9);
    endtask

    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] e;
        bit         seen;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            start1 = 1'b1;
            {x1, y1, c1} = v;
            q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            @(posedge clk);
            #1;
            start1 = 1'b0;
            seen = 0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (valid1) begin
                    seen = 1;
                    e = q1.pop_front();
                    n_cmp++;
                    if ({carry1, sum1} !== e || k !== 2) begin
                        n_err++;
                        $display("FAIL w1 xyc=%b: got {c,s}=%b at edge %0d, expected %b at edge 2",
                                 v, {carry1, sum1}, k, e);
                    end
                end
            end
            if (!seen) begin
                n_cmp++;
                n_err++;
                $display("FAIL w1 xyc=%b timeout: no o_valid", v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] combos [4];
        logic [1:0] e;
        logic       exp_v;
        combos[0] = 3'b111;
        combos[1] = 3'b010;
        combos[2] = 3'b000;
        combos[3] = 3'b101;
        @(negedge clk);
        start1 = 1'b1;
        {x1, y1, c1} = combos[0];
        q1.push_back(2'(combos[0][2]) + 2'(combos[0][1]) + 2'(combos[0][0]));
        @(posedge clk);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            exp_v = (k == 2 || k == 4 || k == 6 || k == 8);
            n_cmp++;
            if (valid1 !== exp_v) begin
                n_err++;
                $display("FAIL b2b valid at edge %0d: got %b, expected %b", k, valid1, exp_v);
            end
            if (valid1 && q1.size() > 0) begin
                e = q1.pop_front();
                n_cmp++;
                if ({carry1, sum1} !== e) begin
                    n_err++;
                    $display("FAIL b2b result at edge %0d: got %b, expected %b", k, {carry1, sum1}, e);
                end
            end
            if (k == 1 || k == 3 || k == 5) begin
                {x1, y1, c1} = combos[(k + 1) / 2];
                q1.push_back(2'(combos[(k + 1) / 2][2]) + 2'(combos[(k + 1) / 2][1])
                             + 2'(combos[(k + 1) / 2][0]));
            end else if (k == 2 || k == 4) begin
                {x1, y1, c1} = 3'($urandom);
                {x1, y1, c1} = combos[k / 2];
            end else if (k == 6) begin
                start1 = 1'b0;
            end
        end
        n_cmp++;
        if (q1.size() !== 0) begin
            n_err++;
            $display("FAIL b2b leftover: got %0d pending, expected 0", q1.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            c = 1'($urandom);
            issue8(x, y, c);
            wait_result8("random", 9);
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_overflow();
        issue8(8'h7F, 8'h01, 1'b0);
        wait_result8("ovf_7F_01", 9);
        issue8(8'h80, 8'h80, 1'b0);
        wait_result8("ovf_80_80", 9);
        issue8(8'h05, 8'h03, 1'b0);
        wait_result8("ovf_05_03", 9);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_while_busy();
        test_reset_mid();
        test_width1();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADDER_OVF_EN
        test_overflow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
